id_stage_decode: RTL and testbench
==================================

// Module: id_stage_decode
// PURPOSE
//  RV32IM instruction decode stage. Accepts fetched words from IF over a valid/ready handshake,
//  decodes each one into the 5-bit ALU opcode and control bits consumed by the execute-stage ALU,
//  generates the immediate, and holds everything in a single-entry ID/EX output register.
//  Sits between the IF/ID register and the execute stage, which holds the ALU.
// PARAMETERS
//  XLEN       32  datapath width
//  ALUOP_W    5   ALU opcode width, equal to the ALU opcode port
// PORTS
//  clk          in   1      rising-edge clock
//  reset_n      in   1      asynchronous, active-low reset
//  flush        in   1      kill the held and incoming instruction (branch taken or trap)
//  in_valid     in   1      IF presents an instruction
//  in_ready     out  1      decode can accept this cycle
//  in_instr     in   32     instruction word
//  in_pc        in   XLEN   PC of in_instr
//  out_valid    out  1      ID/EX register holds a decoded instruction
//  out_ready    in   1      EX consumes the held entry this cycle
//  out_alu_op   out  5      ALU opcode; encoding is in BEHAVIOUR
//  out_imm      out  XLEN   sign-extended immediate
//  out_pc       out  XLEN   PC of the held instruction
//  out_rs1/out_rs2/out_rd  out 5 each  register indices
//  out_src_imm  out  1      ALU data2 = imm (else rs2)
//  out_src_pc   out  1      ALU data1 = pc (else rs1)
//  out_reg_wr, out_mem_rd, out_mem_wr, out_branch, out_jump  out 1 each  control bits
//  out_funct3   out  3      passed through for branch compare and load/store size
//  out_illegal  out  1      unsupported encoding; all write/memory controls are forced to 0
// BEHAVIOUR
//  - Reset: out_valid=0; every other output register=0, which gives alu_op ADD and NOP controls.
//    in_ready is combinational, so it is not a register.
//  - in_ready = !out_valid | out_ready. A transfer occurs when in_valid & in_ready.
//  - Latency: 1 cycle. A word transferred at edge N is visible on the outputs after edge N.
//  - Hold: while out_valid & !out_ready, every output is stable.
//  - Empty: out_valid drops after a consume that has no simultaneous transfer.
//  - Back-to-back transfers sustain full throughput (1 instruction per cycle).
//  - flush (registered effect): next out_valid=0; any same-cycle transfer is discarded.
//    flush has priority over transfer and hold.
//  - reset_n asserted mid-operation clears out_valid immediately; no partial entry survives.
//  - ALU opcode map (shared package constants):
//      ADD=00000  SUB=00001  OR=00010   XOR=00011  AND=00100  SRL=00101
//      SLL=00110  SRA=00111  MUL=01000  MULH=01001 MULHU=01010 MULHSU=01011
//      DIV=01100  DIVU=01101 REM=01110  REMU=01111 SLT=10000  PASS2=10001
//  - OP (0110011), funct7=0000000: add, sll, slt, xor, srl, or, and.
//    funct7=0100000: sub, sra. funct7=0000001: M extension in funct3 order
//    mul, mulh, mulhsu->MULHSU, mulhu->MULHU, div, divu, rem, remu.
//  - SLT and SLTU (and their immediate forms) both map to SLT. Any other funct7 is illegal.
//  - OP-IMM: same map with src_imm=1. SLLI requires funct7=0000000. SRLI/SRAI select on instr[30];
//    shift imm = instr[24:20] zero-extended.
//  - LOAD -> ADD, imm I, mem_rd, reg_wr.  STORE -> ADD, imm S, mem_wr.
//  - BRANCH -> SUB, imm B, branch.  JAL -> ADD, src_pc, imm J, jump, reg_wr.
//  - JALR (funct3=000) -> ADD, imm I, jump, reg_wr.
//  - LUI -> PASS2, imm U.  AUIPC -> ADD, src_pc, imm U.
//  - Any other opcode, or an illegal funct: out_illegal=1, alu_op=ADD, all controls 0.
//    The entry is still delivered with out_valid=1.
//  - rd=0 forces reg_wr=0.
// STRUCTURE
//  - Shared package: ALU opcode localparams (see map), RV32 major opcodes, IMM_I/S/B/U/J selects.
//  - One sub-module, imm_gen: combinational; inputs instr and select, output XLEN sign-extended immediate.
//  - The top level holds the decode logic and the ID/EX register.
// TESTING
//  1 reset: hold reset_n=0 with in_valid=1 -> out_valid=0, out_alu_op=00000, in_ready=1;
//    release reset -> first word is accepted.
//  2 0x40B50533 (sub a0,a0,a1) -> after 1 cycle: alu_op=00001, rd=10, rs1=10, rs2=11, reg_wr=1, src_imm=0.
//  3 0x02B54533 (div a0,a0,a1) -> alu_op=01100.  0x02B53533 (mulhu) -> 01010.
//    0x02B52533 (mulhsu) -> 01011.
//  4 0xFFF00093 (addi x1,x0,-1) -> imm=0xFFFFFFFF, src_imm=1.
//    0x123450B7 (lui) -> alu_op=10001, imm=0x12345000.
//  5 backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable;
//    raise out_ready -> next word is accepted the same cycle and no word is lost.
//  6 flush asserted together with a transfer -> out_valid=0 next cycle.
//    0xFFFFFFFF -> out_illegal=1, reg_wr=0, mem_wr=0.

Source files
------------

// File: rtl/id_stage_decode_pkg.sv
// Shared decode constants: ALU opcode map, RV32 major opcodes, immediate selects.
package id_stage_decode_pkg;

  localparam int XLEN    = 32;
  localparam int ALUOP_W = 5;

  // ALU opcodes understood by the execute-stage ALU
  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b00001;
  localparam logic [4:0] ALU_OR     = 5'b00010;
  localparam logic [4:0] ALU_XOR    = 5'b00011;
  localparam logic [4:0] ALU_AND    = 5'b00100;
  localparam logic [4:0] ALU_SRL    = 5'b00101;
  localparam logic [4:0] ALU_SLL    = 5'b00110;
  localparam logic [4:0] ALU_SRA    = 5'b00111;
  localparam logic [4:0] ALU_MUL    = 5'b01000;
  localparam logic [4:0] ALU_MULH   = 5'b01001;
  localparam logic [4:0] ALU_MULHU  = 5'b01010;
  localparam logic [4:0] ALU_MULHSU = 5'b01011;
  localparam logic [4:0] ALU_DIV    = 5'b01100;
  localparam logic [4:0] ALU_DIVU   = 5'b01101;
  localparam logic [4:0] ALU_REM    = 5'b01110;
  localparam logic [4:0] ALU_REMU   = 5'b01111;
  localparam logic [4:0] ALU_SLT    = 5'b10000;
  localparam logic [4:0] ALU_PASS2  = 5'b10001;

  // RV32 major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Immediate format select; IMM_SH is the zero-extended shift amount
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_SH   = 3'd6
  } imm_sel_e;

  // Shared funct3 -> ALU op map for OP / OP-IMM base integer instructions
  function automatic logic [4:0] base_alu_op(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_stage_decode_imm_gen.sv
// Combinational immediate generator: extracts and sign-extends the selected format.
module imm_gen
  import id_stage_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_sel_e        sel,
  output logic [XLEN-1:0] imm
);

  // Pick the immediate layout; every format except the shift amount is sign-extended
  always_comb begin
    imm = '0;
    case (sel)
      IMM_I:  imm = XLEN'($signed(instr[31:20]));
      IMM_S:  imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B:  imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_U:  imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_J:  imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMM_SH: imm = XLEN'(instr[24:20]);
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage_decode.sv
// RV32IM decode stage: decodes the incoming word and holds it in a single ID/EX entry.
module id_stage_decode
  import id_stage_decode_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [XLEN-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ALUOP_W-1:0] out_alu_op,
  output logic [XLEN-1:0]    out_imm,
  output logic [XLEN-1:0]    out_pc,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [4:0]         out_rd,
  output logic               out_src_imm,
  output logic               out_src_pc,
  output logic               out_reg_wr,
  output logic               out_mem_rd,
  output logic               out_mem_wr,
  output logic               out_branch,
  output logic               out_jump,
  output logic [2:0]         out_funct3,
  output logic               out_illegal
);

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    pc;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic               src_imm;
    logic               src_pc;
    logic               reg_wr;
    logic               mem_rd;
    logic               mem_wr;
    logic               branch;
    logic               jump;
    logic [2:0]         funct3;
    logic               illegal;
  } idex_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  imm_sel_e    imm_sel;
  logic [XLEN-1:0] imm;
  logic [4:0]  alu_op;
  logic        src_imm, src_pc, reg_wr, mem_rd, mem_wr, branch, jump, illegal;

  idex_t entry_q, entry_d;
  logic  valid_q, valid_d;
  logic  transfer;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .sel   (imm_sel),
    .imm   (imm)
  );

  // Decode the incoming word into ALU op, operand selects and control bits
  always_comb begin
    alu_op  = ALU_ADD;
    imm_sel = IMM_NONE;
    src_imm = 1'b0;
    src_pc  = 1'b0;
    reg_wr  = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    branch  = 1'b0;
    jump    = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        reg_wr = 1'b1;
        case (funct7)
          7'b0000000: alu_op = base_alu_op(funct3);
          7'b0100000: begin
            if (funct3 == 3'b000)      alu_op = ALU_SUB;
            else if (funct3 == 3'b101) alu_op = ALU_SRA;
            else                       illegal = 1'b1;
          end
          7'b0000001: begin
            case (funct3)
              3'b000:  alu_op = ALU_MUL;
              3'b001:  alu_op = ALU_MULH;
              3'b010:  alu_op = ALU_MULHSU;
              3'b011:  alu_op = ALU_MULHU;
              3'b100:  alu_op = ALU_DIV;
              3'b101:  alu_op = ALU_DIVU;
              3'b110:  alu_op = ALU_REM;
              default: alu_op = ALU_REMU;
            endcase
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        reg_wr  = 1'b1;
        src_imm = 1'b1;
        imm_sel = IMM_I;
        alu_op  = base_alu_op(funct3);
        if (funct3 == 3'b001) begin
          imm_sel = IMM_SH;
          if (funct7 != 7'b0000000) illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          imm_sel = IMM_SH;
          alu_op  = in_instr[30] ? ALU_SRA : ALU_SRL;
        end
      end
      OPC_LOAD: begin
        imm_sel = IMM_I;
        src_imm = 1'b1;
        mem_rd  = 1'b1;
        reg_wr  = 1'b1;
      end
      OPC_STORE: begin
        imm_sel = IMM_S;
        src_imm = 1'b1;
        mem_wr  = 1'b1;
      end
      OPC_BRANCH: begin
        alu_op  = ALU_SUB;
        imm_sel = IMM_B;
        branch  = 1'b1;
      end
      OPC_JAL: begin
        imm_sel = IMM_J;
        src_pc  = 1'b1;
        src_imm = 1'b1;
        jump    = 1'b1;
        reg_wr  = 1'b1;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          imm_sel = IMM_I;
          src_imm = 1'b1;
          jump    = 1'b1;
          reg_wr  = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        alu_op  = ALU_PASS2;
        imm_sel = IMM_U;
        src_imm = 1'b1;
        reg_wr  = 1'b1;
      end
      OPC_AUIPC: begin
        imm_sel = IMM_U;
        src_pc  = 1'b1;
        src_imm = 1'b1;
        reg_wr  = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // Unsupported encodings become a harmless NOP that still carries the illegal flag
    if (illegal) begin
      alu_op  = ALU_ADD;
      imm_sel = IMM_NONE;
      src_imm = 1'b0;
      src_pc  = 1'b0;
      reg_wr  = 1'b0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      branch  = 1'b0;
      jump    = 1'b0;
    end
    // x0 is hardwired; never request a write to it
    if (rd == 5'd0) reg_wr = 1'b0;
  end

  assign in_ready = !valid_q || out_ready;
  assign transfer = in_valid && in_ready;

  // Next ID/EX entry: flush beats transfer, transfer beats consume, otherwise hold
  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (transfer) begin
      valid_d         = 1'b1;
      entry_d.alu_op  = ALUOP_W'(alu_op);
      entry_d.imm     = imm;
      entry_d.pc      = in_pc;
      entry_d.rs1     = in_instr[19:15];
      entry_d.rs2     = in_instr[24:20];
      entry_d.rd      = rd;
      entry_d.src_imm = src_imm;
      entry_d.src_pc  = src_pc;
      entry_d.reg_wr  = reg_wr;
      entry_d.mem_rd  = mem_rd;
      entry_d.mem_wr  = mem_wr;
      entry_d.branch  = branch;
      entry_d.jump    = jump;
      entry_d.funct3  = funct3;
      entry_d.illegal = illegal;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // ID/EX register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_alu_op  = entry_q.alu_op;
  assign out_imm     = entry_q.imm;
  assign out_pc      = entry_q.pc;
  assign out_rs1     = entry_q.rs1;
  assign out_rs2     = entry_q.rs2;
  assign out_rd      = entry_q.rd;
  assign out_src_imm = entry_q.src_imm;
  assign out_src_pc  = entry_q.src_pc;
  assign out_reg_wr  = entry_q.reg_wr;
  assign out_mem_rd  = entry_q.mem_rd;
  assign out_mem_wr  = entry_q.mem_wr;
  assign out_branch  = entry_q.branch;
  assign out_jump    = entry_q.jump;
  assign out_funct3  = entry_q.funct3;
  assign out_illegal = entry_q.illegal;

endmodule

// File: tb/tb_id_stage_decode.sv
// Directed bench for id_stage_decode with hand-computed expected values.
module tb_id_stage_decode;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_alu_op;
  logic [31:0] out_imm;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_src_imm, out_src_pc, out_reg_wr, out_mem_rd, out_mem_wr;
  logic        out_branch, out_jump, out_illegal;
  logic [2:0]  out_funct3;

  int total;
  int bad;

  id_stage_decode dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_alu_op  (out_alu_op),
    .out_imm     (out_imm),
    .out_pc      (out_pc),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .out_src_imm (out_src_imm),
    .out_src_pc  (out_src_pc),
    .out_reg_wr  (out_reg_wr),
    .out_mem_rd  (out_mem_rd),
    .out_mem_wr  (out_mem_wr),
    .out_branch  (out_branch),
    .out_jump    (out_jump),
    .out_funct3  (out_funct3),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // advance one clock and sample just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h40B50533;   // sub a0,a0,a1
    in_pc     = 32'h0000_0100;
    out_ready = 1'b1;

    // reset held with a word presented
    step();
    step();
    check("rst_valid",  {31'b0, out_valid}, 32'd0);
    check("rst_aluop",  {27'b0, out_alu_op}, 32'd0);
    check("rst_ready",  {31'b0, in_ready}, 32'd1);
    check("rst_regwr",  {31'b0, out_reg_wr}, 32'd0);
    reset_n = 1'b1;

    // first word accepted after release
    step();
    $display("txn sub    instr=%08h alu=%05b", 32'h40B50533, out_alu_op);
    check("sub_valid",  {31'b0, out_valid}, 32'd1);
    check("sub_aluop",  {27'b0, out_alu_op}, 32'h01);
    check("sub_rd",     {27'b0, out_rd}, 32'd10);
    check("sub_rs1",    {27'b0, out_rs1}, 32'd10);
    check("sub_rs2",    {27'b0, out_rs2}, 32'd11);
    check("sub_regwr",  {31'b0, out_reg_wr}, 32'd1);
    check("sub_srcimm", {31'b0, out_src_imm}, 32'd0);
    check("sub_pc",     out_pc, 32'h100);

    // back-to-back stream, one word per cycle
    in_instr = 32'h02B54533; in_pc = 32'h104; step();   // div
    $display("txn div    instr=%08h alu=%05b", 32'h02B54533, out_alu_op);
    check("div_aluop",  {27'b0, out_alu_op}, 32'h0C);
    check("div_pc",     out_pc, 32'h104);

    in_instr = 32'h02B53533; in_pc = 32'h108; step();   // mulhu
    $display("txn mulhu  instr=%08h alu=%05b", 32'h02B53533, out_alu_op);
    check("mulhu_aluop", {27'b0, out_alu_op}, 32'h0A);

    in_instr = 32'h02B52533; in_pc = 32'h10C; step();   // mulhsu
    $display("txn mulhsu instr=%08h alu=%05b", 32'h02B52533, out_alu_op);
    check("mulhsu_aluop", {27'b0, out_alu_op}, 32'h0B);

    in_instr = 32'hFFF00093; in_pc = 32'h110; step();   // addi x1,x0,-1
    $display("txn addi   instr=%08h imm=%08h", 32'hFFF00093, out_imm);
    check("addi_imm",    out_imm, 32'hFFFFFFFF);
    check("addi_srcimm", {31'b0, out_src_imm}, 32'd1);
    check("addi_aluop",  {27'b0, out_alu_op}, 32'h00);

    in_instr = 32'h123450B7; in_pc = 32'h114; step();   // lui x1,0x12345
    $display("txn lui    instr=%08h imm=%08h", 32'h123450B7, out_imm);
    check("lui_aluop",  {27'b0, out_alu_op}, 32'h11);
    check("lui_imm",    out_imm, 32'h12345000);

    in_instr = 32'h00B52423; in_pc = 32'h118; step();   // sw a1,8(a0)
    $display("txn sw     instr=%08h imm=%08h", 32'h00B52423, out_imm);
    check("sw_memwr",   {31'b0, out_mem_wr}, 32'd1);
    check("sw_regwr",   {31'b0, out_reg_wr}, 32'd0);
    check("sw_imm",     out_imm, 32'd8);

    in_instr = 32'h008000EF; in_pc = 32'h11C; step();   // jal x1,8
    $display("txn jal    instr=%08h imm=%08h", 32'h008000EF, out_imm);
    check("jal_jump",   {31'b0, out_jump}, 32'd1);
    check("jal_srcpc",  {31'b0, out_src_pc}, 32'd1);
    check("jal_regwr",  {31'b0, out_reg_wr}, 32'd1);
    check("jal_imm",    out_imm, 32'd8);

    in_instr = 32'hFE000CE3; in_pc = 32'h120; step();   // beq x0,x0,-8
    $display("txn beq    instr=%08h imm=%08h", 32'hFE000CE3, out_imm);
    check("beq_branch", {31'b0, out_branch}, 32'd1);
    check("beq_aluop",  {27'b0, out_alu_op}, 32'h01);
    check("beq_imm",    out_imm, 32'hFFFFFFF8);

    in_instr = 32'h4030D093; in_pc = 32'h124; step();   // srai x1,x1,3
    $display("txn srai   instr=%08h alu=%05b", 32'h4030D093, out_alu_op);
    check("srai_aluop", {27'b0, out_alu_op}, 32'h07);
    check("srai_imm",   out_imm, 32'd3);

    in_instr = 32'h00208033; in_pc = 32'h128; step();   // add x0,x1,x2
    $display("txn add_x0 instr=%08h regwr=%0b", 32'h00208033, out_reg_wr);
    check("addx0_regwr", {31'b0, out_reg_wr}, 32'd0);

    in_instr = 32'h04B50533; in_pc = 32'h12C; step();   // OP with funct7=0000010
    $display("txn badf7  instr=%08h illegal=%0b", 32'h04B50533, out_illegal);
    check("badf7_illegal", {31'b0, out_illegal}, 32'd1);
    check("badf7_regwr",   {31'b0, out_reg_wr}, 32'd0);

    // backpressure: hold div while EX stalls
    in_instr = 32'h02B54533; in_pc = 32'h200; step();
    out_ready = 1'b0;
    in_instr  = 32'hFFF00093; in_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      step();
      $display("txn stall%0d in_ready=%0b alu=%05b pc=%08h", i, in_ready, out_alu_op, out_pc);
      check("bp_inready", {31'b0, in_ready}, 32'd0);
      check("bp_aluop",   {27'b0, out_alu_op}, 32'h0C);
      check("bp_pc",      out_pc, 32'h200);
      check("bp_valid",   {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'b0, in_ready}, 32'd1);
    step();
    $display("txn bp_next pc=%08h imm=%08h", out_pc, out_imm);
    check("bp_next_pc",  out_pc, 32'h204);
    check("bp_next_imm", out_imm, 32'hFFFFFFFF);

    // drain: consume without a new transfer empties the entry
    in_valid = 1'b0;
    step();
    $display("txn drain valid=%0b", out_valid);
    check("empty_valid", {31'b0, out_valid}, 32'd0);

    // flush together with a transfer discards it
    in_valid = 1'b1; in_instr = 32'h40B50533; in_pc = 32'h300; step();
    check("preflush_valid", {31'b0, out_valid}, 32'd1);
    flush = 1'b1; in_instr = 32'h02B54533; in_pc = 32'h304; step();
    $display("txn flush valid=%0b", out_valid);
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    flush = 1'b0; step();
    check("postflush_aluop", {27'b0, out_alu_op}, 32'h0C);
    check("postflush_valid", {31'b0, out_valid}, 32'd1);

    // all-ones word is illegal but still delivered
    in_instr = 32'hFFFFFFFF; in_pc = 32'h308; step();
    $display("txn ones illegal=%0b valid=%0b", out_illegal, out_valid);
    check("ones_illegal", {31'b0, out_illegal}, 32'd1);
    check("ones_regwr",   {31'b0, out_reg_wr}, 32'd0);
    check("ones_memwr",   {31'b0, out_mem_wr}, 32'd0);
    check("ones_valid",   {31'b0, out_valid}, 32'd1);
    check("ones_aluop",   {27'b0, out_alu_op}, 32'h00);

    // asynchronous reset mid-operation clears the entry before the next edge
    reset_n = 1'b0;
    #1;
    $display("txn async_reset valid=%0b", out_valid);
    check("arst_valid", {31'b0, out_valid}, 32'd0);
    check("arst_illegal", {31'b0, out_illegal}, 32'd0);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
